seq_ctrl: RTL and testbench

Instruction sequencer for the 4-entry calculator register file on the nexys3 lab design.
- Accepts one debounced 8-bit instruction word at a time (PUSH/ADD/MULT/SEND).
- Drives register-file read addresses and the write port, and computes the ALU result internally.
- For SEND, serialises the selected register as uppercase ASCII hex plus CR LF onto a valid/ready byte stream feeding the UART transmitter.

---
 rtl/seq_pkg.sv | 43 ++++
 rtl/seq_hex_ascii.sv | 13 +
 rtl/seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the calculator instruction sequencer:
// opcodes, instruction field positions, FSM state encoding and ASCII codes.
package seq_pkg;

  // Opcodes carried in inst_wd[7:6]
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  // Instruction field slices (imm overlaps rb/rc for PUSH)
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RA_HI  = 5;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 2;
  localparam int RC_HI  = 1;
  localparam int RC_LO  = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  // Line terminator appended after every hex dump
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // State encodings kept as plain constants so older tools and netlists
  // see stable values; the enum gives the FSM a named type.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WB   = 3'd2;
  localparam logic [2:0] ST_TX   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_READ = ST_READ,
    S_WB   = ST_WB,
    S_TX   = ST_TX,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/seq_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module seq_hex_ascii (
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F' ('A' - 10 = 0x37)
  always_comb begin
    if (nib < 4'd10) chr = 8'h30 + {4'h0, nib};
    else             chr = 8'h37 + {4'h0, nib};
  end

endmodule

// File: rtl/seq_ctrl.sv
// Instruction sequencer for the 4-entry calculator register file.
// Executes PUSH/ADD/MULT through a read/write-back pair of cycles and
// serialises a register as ASCII hex plus CR LF for SEND.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_vld,
  input  logic [7:0]        inst_wd,
  output logic              inst_rdy,
  output logic [1:0]        rf_ra_addr,
  output logic [1:0]        rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic              rf_we,
  output logic [1:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              tx_vld,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic              inst_done
);

  localparam int N_HEX = DATA_W / 4;
  localparam int IDX_W = $clog2(N_HEX + 2);

  state_t            state;
  logic [7:0]        inst_q;
  logic [DATA_W-1:0] shadow;
  logic [IDX_W-1:0]  idx;

  logic [1:0]        op;
  logic [1:0]        ra;
  logic [1:0]        rb;
  logic [1:0]        rc;
  logic [3:0]        imm;
  logic [DATA_W-1:0] alu;
  logic [3:0]        nib;
  logic [7:0]        hex_chr;
  logic [7:0]        byte_sel;
  logic              xfer;
  logic              last;

  assign op  = inst_q[OP_HI:OP_LO];
  assign ra  = inst_q[RA_HI:RA_LO];
  assign rb  = inst_q[RB_HI:RB_LO];
  assign rc  = inst_q[RC_HI:RC_LO];
  assign imm = inst_q[IMM_HI:IMM_LO];

  assign inst_rdy = (state == S_IDLE);
  assign tx_vld   = (state == S_TX);
  // Forced to zero outside TX so the idle bus reads as 0, not '0'
  assign tx_data  = tx_vld ? byte_sel : 8'h00;
  assign xfer     = tx_vld & tx_rdy;
  assign last     = (idx == IDX_W'(N_HEX + 1));

  // Read addresses follow the latched instruction; the register file
  // answers combinationally, so they only matter during READ.
  always_comb begin
    rf_ra_addr = ra;
    rf_rb_addr = 2'd0;
    if (op == OP_ADD || op == OP_MULT) begin
      rf_ra_addr = rb;
      rf_rb_addr = rc;
    end
  end

  // ALU on READ-cycle operands; all results wrap to DATA_W bits
  always_comb begin
    case (op)
      OP_PUSH: alu = {rf_ra_data[DATA_W-5:0], imm};
      OP_ADD:  alu = rf_ra_data + rf_rb_data;
      OP_MULT: alu = rf_ra_data * rf_rb_data;
      default: alu = '0;
    endcase
  end

  // Pick the nibble for the current character, most significant first
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < N_HEX; i++) begin
      if (idx == IDX_W'(N_HEX - 1 - i)) nib = shadow[i*4 +: 4];
    end
  end

  seq_hex_ascii u_hex (
    .nib (nib),
    .chr (hex_chr)
  );

  // Frame byte: hex digits, then CR, then LF
  always_comb begin
    if (idx < IDX_W'(N_HEX))       byte_sel = hex_chr;
    else if (idx == IDX_W'(N_HEX)) byte_sel = ASCII_CR;
    else                           byte_sel = ASCII_LF;
  end

  // Sequencer FSM; rf_we and inst_done are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      inst_q    <= '0;
      shadow    <= '0;
      idx       <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= 2'd0;
      rf_wd     <= '0;
      inst_done <= 1'b0;
    end else begin
      rf_we     <= 1'b0;
      inst_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_vld) begin
            inst_q <= inst_wd;
            state  <= S_READ;
          end
        end
        S_READ: begin
          if (op == OP_SEND) begin
            shadow <= rf_ra_data;
            idx    <= '0;
            state  <= S_TX;
          end else begin
            rf_we     <= 1'b1;
            rf_wa     <= ra;
            rf_wd     <= alu;
            inst_done <= 1'b1;
            state     <= S_WB;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        S_TX: begin
          if (xfer) begin
            if (last) begin
              inst_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with a behavioural 4 x 8-bit register file.
module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inst_vld = 1'b0;
  logic [7:0] inst_wd = 8'h00;
  logic       tx_rdy = 1'b0;
  logic       inst_rdy;
  logic [1:0] rf_ra_addr;
  logic [1:0] rf_rb_addr;
  logic [7:0] rf_ra_data;
  logic [7:0] rf_rb_data;
  logic       rf_we;
  logic [1:0] rf_wa;
  logic [7:0] rf_wd;
  logic       tx_vld;
  logic [7:0] tx_data;
  logic       inst_done;

  int tests = 0;
  int fails = 0;

  seq_ctrl #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_vld   (inst_vld),
    .inst_wd    (inst_wd),
    .inst_rdy   (inst_rdy),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_ra_data (rf_ra_data),
    .rf_rb_data (rf_rb_data),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .tx_vld     (tx_vld),
    .tx_data    (tx_data),
    .tx_rdy     (tx_rdy),
    .inst_done  (inst_done)
  );

  always #5 clk = ~clk;

  // Register file model: asynchronous read, synchronous write
  logic [7:0] rf [4] = '{default: 8'h00};
  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];
  always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;

  typedef struct {
    string      name;
    logic [7:0] wd;
    logic [1:0] wa;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] exp_send [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one write-back instruction and check the accept+1/+2/+3 timing
  task automatic run_inst(input string nm, input logic [7:0] w,
                          input logic [1:0] wa, input logic [7:0] wd);
    @(negedge clk);
    chk({nm, " rdy"}, inst_rdy, 1);
    inst_vld = 1'b1;
    inst_wd  = w;
    @(negedge clk);
    inst_vld = 1'b0;
    chk({nm, " read_we"}, rf_we, 0);
    @(negedge clk);
    chk({nm, " we"}, rf_we, 1);
    chk({nm, " wa"}, rf_wa, wa);
    chk({nm, " wd"}, rf_wd, wd);
    chk({nm, " done"}, inst_done, 1);
    @(negedge clk);
    chk({nm, " rdy_after"}, inst_rdy, 1);
    chk({nm, " we_after"}, rf_we, 0);
    chk({nm, " done_after"}, inst_done, 0);
  endtask

  // Accept a SEND of the given register; returns in the READ cycle
  task automatic start_send(input string nm, input logic [1:0] ra);
    @(negedge clk);
    chk({nm, " rdy"}, inst_rdy, 1);
    inst_vld = 1'b1;
    inst_wd  = {2'b11, ra, 4'h0};
    @(negedge clk);
    inst_vld = 1'b0;
    chk({nm, " read_vld"}, tx_vld, 0);
    chk({nm, " read_addr"}, rf_ra_addr, ra);
  endtask

  initial begin
    vecs[0] = '{"push0_4",   8'h04, 2'd0, 8'h04};
    vecs[1] = '{"push0_0",   8'h00, 2'd0, 8'h40};
    vecs[2] = '{"push1_3",   8'h13, 2'd1, 8'h03};
    vecs[3] = '{"mult2_0_1", 8'hA1, 2'd2, 8'hC0};
    vecs[4] = '{"add3_2_0",  8'h78, 2'd3, 8'h00};
    vecs[5] = '{"push1_8",   8'h18, 2'd1, 8'h38};
    vecs[6] = '{"push1_1",   8'h11, 2'd1, 8'h81};
    vecs[7] = '{"add1_1_1",  8'h55, 2'd1, 8'h02};
    exp_send = '{8'h43, 8'h30, 8'h0D, 8'h0A};

    // Reset state
    @(negedge clk);
    chk("rst inst_rdy", inst_rdy, 1);
    chk("rst rf_we", rf_we, 0);
    chk("rst rf_wa", rf_wa, 0);
    chk("rst rf_wd", rf_wd, 0);
    chk("rst tx_vld", tx_vld, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst inst_done", inst_done, 0);
    chk("rst ra_addr", rf_ra_addr, 0);
    chk("rst rb_addr", rf_rb_addr, 0);
    rst = 1'b0;

    // PUSH / ADD / MULT vectors, including wrap and self-operand cases
    for (int i = 0; i < 8; i++) run_inst(vecs[i].name, vecs[i].wd, vecs[i].wa, vecs[i].exp);

    // SEND r2 = 0xC0 with the receiver always ready
    tx_rdy = 1'b1;
    start_send("send_fast", 2'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("send_fast vld", tx_vld, 1);
      chk("send_fast byte", tx_data, exp_send[i]);
      chk("send_fast we", rf_we, 0);
      chk("send_fast rdy", inst_rdy, 0);
    end
    @(negedge clk);
    chk("send_fast end_vld", tx_vld, 0);
    chk("send_fast done", inst_done, 1);
    @(negedge clk);
    chk("send_fast done_pulse", inst_done, 0);
    chk("send_fast idle", inst_rdy, 1);

    // SEND with back-pressure on the first byte and a stray instruction
    tx_rdy = 1'b0;
    start_send("send_stall", 2'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("send_stall vld", tx_vld, 1);
      chk("send_stall byte", tx_data, 8'h43);
      chk("send_stall we", rf_we, 0);
      if (i == 1) begin
        inst_vld = 1'b1;
        inst_wd  = 8'h0F;
      end
      if (i == 2) inst_vld = 1'b0;
      if (i == 4) tx_rdy = 1'b1;
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("send_stall vld2", tx_vld, 1);
      chk("send_stall byte2", tx_data, exp_send[i]);
      chk("send_stall we2", rf_we, 0);
    end
    @(negedge clk);
    chk("send_stall end_vld", tx_vld, 0);
    chk("send_stall done", inst_done, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("send_stall quiet_vld", tx_vld, 0);
      chk("send_stall quiet_we", rf_we, 0);
      chk("send_stall idle", inst_rdy, 1);
    end
    chk("send_stall r0_kept", rf[0], 8'h40);

    // Reset in the middle of a SEND after two bytes have gone
    start_send("send_abort", 2'd2);
    @(negedge clk);
    chk("send_abort b0", tx_data, 8'h43);
    @(negedge clk);
    chk("send_abort b1", tx_data, 8'h30);
    @(negedge clk);
    chk("send_abort b2", tx_data, 8'h0D);
    rst = 1'b1;
    #1;
    chk("abort vld", tx_vld, 0);
    chk("abort rdy", inst_rdy, 1);
    chk("abort data", tx_data, 0);
    chk("abort done", inst_done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort quiet_vld", tx_vld, 0);
      chk("abort quiet_we", rf_we, 0);
    end
    run_inst("push2_5", 8'h25, 2'd2, 8'h05);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
